// File: rtl/forward_stall_ctrl.sv
// forward_stall_ctrl: EX-stage forwarding select generation, load-use and
// multiply/divide hazard stall detection, and a one-deep MD scoreboard.
// Selects are computed in ID and registered into EX with the instruction.
module forward_stall_ctrl #(
    parameter int REG_BITS   = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_is_md,
    input  logic [REG_BITS-1:0] id_md_rd,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_regwrite,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                stall,
    output logic                md_busy,
    output logic                md_wb,
    output logic [REG_BITS-1:0] md_wb_rd
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAT = CW'(MD_LATENCY);

    // Forwarding mux encodings
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_MD  = 2'b11;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [REG_BITS-1:0] r_md_rd, w_md_rd_nxt;
    logic                r_md_wb, w_md_wb_nxt;
    logic [REG_BITS-1:0] r_md_wb_rd, w_md_wb_rd_nxt;
    logic [1:0]          r_fwd_a, r_fwd_b;
    logic [1:0]          w_fwd_a_nxt, w_fwd_b_nxt;

    logic w_use_rs, w_use_rt;
    logic w_load_use, w_md_raw, w_md_struct, w_md_waw;
    logic w_stall, w_md_issue;
    logic w_busy;

    // Register $0 is hardwired, so it never matches a producer.
    function automatic logic f_match(input logic [REG_BITS-1:0] r,
                                     input logic [REG_BITS-1:0] d);
        return (d != '0) && (r == d);
    endfunction

    // Newest producer wins: EX, then MEM, then an MD result landing next cycle.
    function automatic logic [1:0] f_sel(input logic                used,
                                         input logic [REG_BITS-1:0] src,
                                         input logic                ex_w,
                                         input logic [REG_BITS-1:0] ex_d,
                                         input logic                mem_w,
                                         input logic [REG_BITS-1:0] mem_d,
                                         input logic                md_ready,
                                         input logic [REG_BITS-1:0] md_d);
        logic [1:0] s;
        s = SEL_RF;
        if (used) begin
            if (ex_w && f_match(src, ex_d))
                s = SEL_EX;
            else if (mem_w && f_match(src, mem_d))
                s = SEL_MEM;
            else if (md_ready && f_match(src, md_d))
                s = SEL_MD;
        end
        return s;
    endfunction

    assign w_busy   = (r_state == S_BUSY);
    assign w_use_rs = id_valid && id_uses_rs;
    assign w_use_rt = id_valid && id_uses_rt;

    // Hazard detection; each term only matters for a real instruction in ID.
    always_comb begin
        w_load_use  = 1'b0;
        w_md_raw    = 1'b0;
        w_md_struct = 1'b0;
        w_md_waw    = 1'b0;
        if (id_valid) begin
            // Load data is not available until MEM, one cycle too late for EX.
            w_load_use = ex_memread && ex_regwrite &&
                         ((w_use_rs && f_match(id_rs, ex_rd)) ||
                          (w_use_rt && f_match(id_rt, ex_rd)));
            // MD result is forwardable only once cnt reaches 2.
            w_md_raw = w_busy && (r_cnt > 4'd2) &&
                       ((w_use_rs && f_match(id_rs, r_md_rd)) ||
                        (w_use_rt && f_match(id_rt, r_md_rd)));
            // Single MD unit: a new op may issue only in the last busy cycle.
            w_md_struct = id_is_md && w_busy && (r_cnt > 4'd1);
            // A normal write must not land before the older MD write.
            w_md_waw = id_regwrite && w_busy && (r_cnt > 4'd1) &&
                       f_match(id_rd, r_md_rd);
        end
    end

    assign w_stall    = w_load_use || w_md_raw || w_md_struct || w_md_waw;
    assign w_md_issue = id_valid && id_is_md && !w_stall;

    // Next forwarding selects; a stall or empty ID slot injects a bubble.
    always_comb begin
        w_fwd_a_nxt = SEL_RF;
        w_fwd_b_nxt = SEL_RF;
        if (id_valid && !w_stall) begin
            w_fwd_a_nxt = f_sel(w_use_rs, id_rs, ex_regwrite, ex_rd,
                                mem_regwrite, mem_rd,
                                w_busy && (r_cnt == 4'd2), r_md_rd);
            w_fwd_b_nxt = f_sel(w_use_rt, id_rt, ex_regwrite, ex_rd,
                                mem_regwrite, mem_rd,
                                w_busy && (r_cnt == 4'd2), r_md_rd);
        end
    end

    // MD scoreboard next state; the counter runs regardless of stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_md_rd_nxt    = r_md_rd;
        w_md_wb_nxt    = 1'b0;
        w_md_wb_rd_nxt = r_md_wb_rd;
        case (r_state)
            S_IDLE: begin
                if (w_md_issue) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = LAT;
                    w_md_rd_nxt = id_md_rd;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd2) begin
                    w_md_wb_nxt    = 1'b1;
                    w_md_wb_rd_nxt = r_md_rd;
                end
                if (r_cnt <= 4'd1) begin
                    // Last busy cycle: either retire or accept a back-to-back op.
                    if (w_md_issue) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = LAT;
                        w_md_rd_nxt = id_md_rd;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding MD op.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_md_rd    <= '0;
            r_md_wb    <= 1'b0;
            r_md_wb_rd <= '0;
            r_fwd_a    <= SEL_RF;
            r_fwd_b    <= SEL_RF;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_md_rd    <= w_md_rd_nxt;
            r_md_wb    <= w_md_wb_nxt;
            r_md_wb_rd <= w_md_wb_rd_nxt;
            r_fwd_a    <= w_fwd_a_nxt;
            r_fwd_b    <= w_fwd_b_nxt;
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
    assign stall     = w_stall;
    assign md_busy   = w_busy;
    assign md_wb     = r_md_wb;
    assign md_wb_rd  = r_md_wb_rd;

endmodule
